grid_mem_arbiter: RTL and testbench
===================================

GRID_MEM_ARBITER -- requirements
Module: grid_mem_arbiter

Interface
REQ-001 Parameter GRID_COLS, default 12, grid width in cells.
REQ-002 Parameter GRID_ROWS, default 20, grid height in cells; GRID_CELLS = GRID_COLS*GRID_ROWS = 240.
REQ-003 Parameter BORDER_CODE, default 8'd8, cell code written to border cells by the clear sequence.
REQ-004 px_clk  in  1  pixel clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 px_en  in  1  active-video flag; video owns the memory port whenever it is high.
REQ-007 vid_addr  in  8  video-side grid cell address.
REQ-008 vid_data  out  8  grid cell data for vid_addr, 1 cycle after the address.
REQ-009 g_req  in  1  game access request, held high until g_ack.
REQ-010 g_we  in  1  game write enable, qualified by g_req.
REQ-011 g_addr  in  8  game cell address.
REQ-012 g_wdata  in  8  game write data.
REQ-013 g_ack  out  1  single-cycle pulse: game access complete.
REQ-014 g_rdata  out  8  game read data, valid while g_ack=1.
REQ-015 g_err  out  1  pulses with g_ack when g_addr >= GRID_CELLS.
REQ-016 clr_start  in  1  single-cycle pulse requesting a full-grid clear.
REQ-017 clr_busy  out  1  high while the clear sequence is running.
REQ-018 mem_addr  out  8  address to the single-port synchronous grid RAM.
REQ-019 mem_we  out  1  RAM write enable.
REQ-020 mem_wdata  out  8  RAM write data.
REQ-021 mem_rdata  in  8  RAM read data, valid 1 cycle after the address.

Function
REQ-022 Port priority per cycle: video (px_en=1) > clear > game; exactly one owner per cycle.
REQ-023 Video cycle: mem_addr=vid_addr, mem_we=0; vid_data is registered from mem_rdata on the following edge; vid_data=0 on the cycle after any non-video cycle.
REQ-024 The FSM shall have states IDLE, VIDEO, CLEAR, G_ISSUE, G_DONE.
REQ-025 IDLE: px_en=1 -> VIDEO; else clear pending -> CLEAR; else g_req=1 -> G_ISSUE; else stay.
REQ-026 VIDEO: stay while px_en=1; on px_en=0 -> IDLE.
REQ-027 G_ISSUE: drives mem_addr=g_addr, mem_we=g_we; -> G_DONE on the next edge regardless of px_en.
REQ-028 G_DONE: g_ack=1, g_rdata=mem_rdata captured (0 for writes); port is free for video in this cycle; -> VIDEO if px_en=1, else IDLE.
REQ-029 G_ISSUE shall be entered only when px_en=0 in that cycle; the game request sees a latency of exactly 2 cycles from grant to ack.
REQ-030 Out-of-range game address (>= GRID_CELLS): mem_we forced 0 in G_ISSUE, g_rdata=0, g_err=1 with g_ack.
REQ-031 clr_start sets a clear-pending flag; clr_busy rises on the next edge; clr_start while clr_busy is ignored.
REQ-032 CLEAR: writes one cell per cycle at clr_ptr, starting at 0; value = BORDER_CODE if col==0, col==GRID_COLS-1 or row==GRID_ROWS-1, else 0.
REQ-033 The clear row/col counters wrap col at GRID_COLS-1 and increment row; mem_addr = row*GRID_COLS+col.
REQ-034 px_en=1 during CLEAR: pause on the current cell (not written), -> VIDEO, resume the same cell on return via IDLE.
REQ-035 After cell GRID_CELLS-1 is written: clr_busy=0, -> IDLE; g_req pending during clear is served afterwards.
REQ-036 g_req dropped before g_ack: no access issued if not yet in G_ISSUE; an access in G_ISSUE still completes and acks.

Reset
REQ-037 On reset: state IDLE, vid_data=0, g_ack=0, g_rdata=0, g_err=0, clr_busy=0, clear flag and counters 0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-038 reset asserted mid-clear or mid-game access aborts it without ack; no write occurs after reset assertion.

Verification
REQ-039 px_en=1, vid_addr=5, RAM[5]=8'h03 -> vid_data=8'h03 one cycle later, mem_we never high.
REQ-040 px_en=0, g_req write addr 17 data 8'h04 -> mem_we=1 addr 17 in cycle 1, g_ack in cycle 2; read back returns 8'h04.
REQ-041 g_req read addr 240 -> g_ack and g_err together, g_rdata=0, no write.
REQ-042 clr_start with px_en=0 -> 240 writes in 240 cycles; RAM[0]=8, RAM[13]=0, RAM[11]=8, RAM[228..239]=8; clr_busy falls after cell 239.
REQ-043 px_en raised for 10 cycles mid-clear at cell 50 -> cell 50 written after px_en falls, clr_busy duration 250 cycles total.
REQ-044 g_req held during clear then px_en=1 at G_ISSUE+1 -> ack still delivered in G_DONE, video addresses drive mem_addr from that cycle.

Source files
------------

// File: rtl/grid_mem_arbiter.sv
// Single-port grid RAM arbiter. Every px_clk cycle the port goes to video scan-out,
// then the full-grid clear sequence, then game accesses, in that priority.
module grid_mem_arbiter #(
  parameter int unsigned GRID_COLS   = 12,
  parameter int unsigned GRID_ROWS   = 20,
  parameter logic [7:0]  BORDER_CODE = 8'd8
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       px_en,
  input  logic [7:0] vid_addr,
  output logic [7:0] vid_data,
  input  logic       g_req,
  input  logic       g_we,
  input  logic [7:0] g_addr,
  input  logic [7:0] g_wdata,
  output logic       g_ack,
  output logic [7:0] g_rdata,
  output logic       g_err,
  input  logic       clr_start,
  output logic       clr_busy,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);
  localparam int unsigned GRID_CELLS = GRID_COLS * GRID_ROWS;
  localparam int unsigned CW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int unsigned RW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam logic [8:0]    CELLS_LIM = 9'(GRID_CELLS);
  localparam logic [CW-1:0] COL_LAST  = CW'(GRID_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(GRID_ROWS - 1);

  typedef enum logic [2:0] {IDLE, VIDEO, CLEAR, G_ISSUE, G_DONE} state_t;

  typedef struct packed {
    logic       we;
    logic       oor;
    logic [7:0] addr;
    logic [7:0] wdata;
  } greq_t;

  state_t        state_q;
  greq_t         greq_q, greq_d;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          clr_busy_q;
  logic          vid_vld_q;

  logic       vid_go, clr_go, clr_last, clr_border;
  logic [7:0] clr_addr;

  // G_ISSUE keeps the port even if px_en rises, so a granted access always lands.
  always_comb begin
    clr_addr   = 8'(32'(row_q) * GRID_COLS + 32'(col_q));
    clr_border = (col_q == '0) || (col_q == COL_LAST) || (row_q == ROW_LAST);
    clr_last   = (col_q == COL_LAST) && (row_q == ROW_LAST);
    vid_go     = px_en && (state_q != G_ISSUE);
    clr_go     = !px_en && clr_busy_q && (state_q != G_ISSUE);
    greq_d     = '{we: g_we, oor: ({1'b0, g_addr} >= CELLS_LIM), addr: g_addr, wdata: g_wdata};
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    if (!reset) begin
      if (state_q == G_ISSUE) begin
        mem_addr  = greq_q.addr;
        mem_we    = greq_q.we && !greq_q.oor;
        mem_wdata = greq_q.wdata;
      end else if (vid_go) begin
        mem_addr = vid_addr;
      end else if (clr_go) begin
        mem_addr  = clr_addr;
        mem_we    = 1'b1;
        mem_wdata = clr_border ? BORDER_CODE : 8'd0;
      end
    end
  end

  // Read data comes straight off the RAM output register, qualified by our own flags.
  assign g_ack    = (state_q == G_DONE);
  assign g_err    = g_ack && greq_q.oor;
  assign g_rdata  = (g_ack && !greq_q.we && !greq_q.oor) ? mem_rdata : 8'd0;
  assign vid_data = vid_vld_q ? mem_rdata : 8'd0;
  assign clr_busy = clr_busy_q;

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      greq_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      clr_busy_q <= 1'b0;
      vid_vld_q  <= 1'b0;
    end else begin
      vid_vld_q <= vid_go;
      if (clr_go) begin
        if (clr_last) begin
          row_q      <= '0;
          col_q      <= '0;
          clr_busy_q <= 1'b0;
        end else if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else if (clr_start) begin
        clr_busy_q <= 1'b1;
      end
      unique case (state_q)
        G_ISSUE:       state_q <= G_DONE;
        VIDEO, G_DONE: state_q <= px_en ? VIDEO : IDLE;
        default: begin
          if (px_en) begin
            state_q <= VIDEO;
          end else if (clr_busy_q) begin
            state_q <= clr_last ? IDLE : CLEAR;
          end else if (g_req && (state_q == IDLE)) begin
            state_q <= G_ISSUE;
            greq_q  <= greq_d;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Randomized bench for grid_mem_arbiter: a cycle model of port ownership over a
// linear clear pointer and a shadow RAM, plus directed literal scenarios.
module tb_grid_mem_arbiter;
  localparam int COLS = 12, ROWS = 20, CELLS = 240;
  localparam logic [7:0] BORDER = 8'd8;
  localparam int S_IDLE = 0, S_VID = 1, S_CLR = 2, S_ISS = 3, S_DONE = 4;

  logic px_clk = 0, reset = 0, px_en = 0, g_req = 0, g_we = 0, clr_start = 0;
  logic [7:0] vid_addr = 0, g_addr = 0, g_wdata = 0;
  logic [7:0] vid_data, g_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       g_ack, g_err, clr_busy, mem_we;

  grid_mem_arbiter #(.GRID_COLS(COLS), .GRID_ROWS(ROWS), .BORDER_CODE(BORDER)) dut (
    .px_clk(px_clk), .reset(reset), .px_en(px_en), .vid_addr(vid_addr), .vid_data(vid_data),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata), .g_ack(g_ack),
    .g_rdata(g_rdata), .g_err(g_err), .clr_start(clr_start), .clr_busy(clr_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  always #5 px_clk = ~px_clk;

  logic [7:0] ram [256] = '{default: 8'h00};
  always @(posedge px_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_chk = 0, n_fail = 0;
  // model state
  int         m_st = S_IDLE, m_ptr = 0;
  bit         m_clr = 0, m_vprev = 0, m_gwe = 0, m_goor = 0;
  logic [7:0] m_vexp = 0, m_rexp = 0, m_gaddr = 0, m_gwdata = 0;
  logic [7:0] mref [256] = '{default: 8'h00};
  // observed outputs of the last checked cycle
  bit         o_ack, o_err, o_busy, o_we;
  logic [7:0] o_rdata, o_vdata, o_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_border(input int p);
    return (p % COLS == 0) || (p % COLS == COLS - 1) || (p / COLS == ROWS - 1);
  endfunction

  task automatic model_cycle();
    int own, nst;
    bit last, ewe;
    o_ack = g_ack; o_err = g_err; o_busy = clr_busy; o_we = mem_we;
    o_rdata = g_rdata; o_vdata = vid_data; o_addr = mem_addr;
    if (reset) begin
      chk("rst_vid_data", vid_data, 0);  chk("rst_g_ack", g_ack, 0);
      chk("rst_g_rdata", g_rdata, 0);    chk("rst_g_err", g_err, 0);
      chk("rst_clr_busy", clr_busy, 0);  chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);  chk("rst_mem_wdata", mem_wdata, 0);
      m_st = S_IDLE; m_clr = 0; m_ptr = 0; m_vprev = 0; m_rexp = 0;
      return;
    end
    // owner: 0 none, 1 video, 2 clear, 3 game
    own = (m_st == S_ISS) ? 3 : px_en ? 1 : m_clr ? 2 : 0;
    chk("g_ack", g_ack, m_st == S_DONE);
    chk("g_err", g_err, (m_st == S_DONE) && m_goor);
    chk("g_rdata", g_rdata, (m_st == S_DONE) ? m_rexp : 8'd0);
    chk("vid_data", vid_data, m_vprev ? m_vexp : 8'd0);
    chk("clr_busy", clr_busy, m_clr);
    ewe = (own == 2) || (own == 3 && m_gwe && !m_goor);
    chk("mem_we", mem_we, ewe);
    if (own == 1) chk("mem_addr_vid", mem_addr, vid_addr);
    if (own == 2) begin
      chk("mem_addr_clr", mem_addr, m_ptr);
      chk("mem_wdata_clr", mem_wdata, is_border(m_ptr) ? BORDER : 8'd0);
    end
    if (own == 3) chk("mem_addr_game", mem_addr, m_gaddr);
    if (own == 3 && ewe) chk("mem_wdata_game", mem_wdata, m_gwdata);

    last = (own == 2) && (m_ptr == CELLS - 1);
    case (m_st)
      S_ISS:         nst = S_DONE;
      S_VID, S_DONE: nst = px_en ? S_VID : S_IDLE;
      default: begin
        if (px_en)                        nst = S_VID;
        else if (m_clr)                   nst = last ? S_IDLE : S_CLR;
        else if (m_st == S_IDLE && g_req) nst = S_ISS;
        else                              nst = S_IDLE;
      end
    endcase
    m_vprev = (own == 1);
    if (own == 1) m_vexp = mref[vid_addr];
    if (own == 3) begin
      m_rexp = (!m_gwe && !m_goor) ? mref[m_gaddr] : 8'd0;
      if (m_gwe && !m_goor) mref[m_gaddr] = m_gwdata;
    end
    if (own == 2) begin
      mref[m_ptr] = is_border(m_ptr) ? BORDER : 8'd0;
      if (last) begin m_clr = 0; m_ptr = 0; end
      else m_ptr++;
    end else if (clr_start) begin
      m_clr = 1;
    end
    if (nst == S_ISS) begin
      m_gwe = g_we; m_gaddr = g_addr; m_gwdata = g_wdata; m_goor = (int'(g_addr) >= CELLS);
    end
    m_st = nst;
  endtask

  task automatic step();
    @(negedge px_clk);
    model_cycle();
    @(posedge px_clk);
    #1;
  endtask

  task automatic game(input bit we, input logic [7:0] a, input logic [7:0] d,
                      output int lat, output logic [7:0] rd, output bit er);
    g_req = 1; g_we = we; g_addr = a; g_wdata = d; lat = -1; rd = 0; er = 0;
    for (int i = 0; i < 600 && lat < 0; i++) begin
      step();
      if (o_ack) begin lat = i; rd = o_rdata; er = o_err; end
    end
    g_req = 0;
    if (lat < 0) chk("game_timeout", 0, 1);
  endtask

  task automatic run_clear(input int pause_at, output int busy_cyc, output int writes);
    bit done = 0;
    clr_start = 1; step(); clr_start = 0;
    busy_cyc = 0; writes = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (pause_at >= 0 && writes == pause_at) begin
        px_en = 1;
        repeat (10) begin
          step();
          if (o_busy) begin busy_cyc++; if (o_we) writes++; end
        end
        px_en = 0; pause_at = -1;
      end
      step();
      if (o_busy) begin busy_cyc++; if (o_we) writes++; end
      else done = 1;
    end
    if (!done) chk("clear_timeout", 0, 1);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, wc;
    logic [7:0] rd;
    bit er, gact, found;
    int gwait;
    int chk_addr [5] = '{0, 13, 11, 228, 239};
    logic [7:0] chk_val [5] = '{8'd8, 8'd0, 8'd8, 8'd8, 8'd8};

    #1 reset = 1; px_en = 1; vid_addr = 8'h33;
    repeat (3) step();
    reset = 0; px_en = 0;
    step();

    game(1, 8'd17, 8'h04, lat, rd, er);
    chk("wr17_latency", lat, 2);
    game(0, 8'd17, 8'h00, lat, rd, er);
    chk("rd17_data", rd, 8'h04);
    chk("rd17_err", er, 0);

    game(1, 8'd5, 8'h03, lat, rd, er);
    px_en = 1; vid_addr = 8'd5; step();
    px_en = 0; step();
    chk("vid5_data", o_vdata, 8'h03);

    game(0, 8'd240, 8'h00, lat, rd, er);
    chk("oor_err", er, 1);
    chk("oor_rdata", rd, 0);
    chk("oor_latency", lat, 2);

    run_clear(-1, bc, wc);
    chk("clear_busy_cycles", bc, 240);
    chk("clear_writes", wc, 240);
    for (int i = 0; i < 5; i++) begin
      game(0, 8'(chk_addr[i]), 8'h00, lat, rd, er);
      chk("clear_cell", rd, chk_val[i]);
    end

    game(1, 8'd50, 8'hAA, lat, rd, er);
    game(1, 8'd48, 8'hAA, lat, rd, er);
    vid_addr = 8'd20;
    run_clear(50, bc, wc);
    chk("pause_busy_cycles", bc, 250);
    chk("pause_writes", wc, 240);
    game(0, 8'd50, 8'h00, lat, rd, er);
    chk("pause_cell50", rd, 8'h00);
    game(0, 8'd48, 8'h00, lat, rd, er);
    chk("pause_cell48", rd, 8'h08);

    // game write queued behind a clear, video returns right after G_ISSUE
    clr_start = 1; step(); clr_start = 0;
    g_req = 1; g_we = 1; g_addr = 8'd100; g_wdata = 8'h55; found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (o_we && o_addr == 8'd100 && !o_busy) found = 1;
    end
    chk("queued_issue_seen", found, 1);
    px_en = 1; vid_addr = 8'd11; step();
    chk("queued_ack", o_ack, 1);
    chk("queued_vid_addr", o_addr, 8'd11);
    g_req = 0; step();
    chk("queued_vid_data", o_vdata, 8'h08);
    px_en = 0; step();
    game(0, 8'd100, 8'h00, lat, rd, er);
    chk("queued_rd100", rd, 8'h55);

    gact = 0; gwait = 0;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 15) == 0) px_en = ~px_en;
      vid_addr  = 8'($urandom);
      clr_start = ($urandom_range(0, 299) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      if (!gact && $urandom_range(0, 3) == 0) begin
        gact = 1; gwait = 0; g_req = 1; g_we = 1'($urandom_range(0, 1));
        g_addr  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 239));
        g_wdata = 8'($urandom);
      end else if (gact && $urandom_range(0, 49) == 0) begin
        gact = 0; g_req = 0;
      end
      step();
      if (gact) begin
        gwait++;
        if (o_ack) begin gact = 0; g_req = 0; end
        else if (gwait > 1500) begin chk("rand_game_timeout", 0, 1); gact = 0; g_req = 0; end
      end
    end
    reset = 0; px_en = 0; g_req = 0; clr_start = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
